// File: rtl/periph_buttons_pkg.sv
// periph_buttons_pkg
//   Shared constants for the io-bus peripherals: register byte offsets of the
//   push-button block and the bus handshake state encoding, which periph_leds
//   reuses so both slaves speak the same read/write/ready protocol.
package periph_buttons_pkg;

  // Register byte offsets inside the block (bits [1:0] are always 0).
  localparam logic [31:0] BTN_REG_STATE = 32'h00;
  localparam logic [31:0] BTN_REG_EDGE  = 32'h04;
  localparam logic [31:0] BTN_REG_IRQEN = 32'h08;
  localparam logic [31:0] BTN_REG_RAW   = 32'h0C;
  localparam logic [31:0] BTN_REG_FALL  = 32'h10;

  // Slave side of the CPU data-bus handshake.
  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WAIT = 2'd1,
    BUS_ACK  = 2'd2,
    BUS_DONE = 2'd3
  } bus_state_e;

endpackage

// File: rtl/periph_buttons_debounce.sv
// btn_debounce
//   One button bit: 2-flop synchroniser followed by a consecutive-mismatch
//   counter. The stable level only follows the synchronised level after
//   DEB_CYCLES back-to-back clocks of disagreement.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   pin_i      raw asynchronous pin
//   raw_o      synchroniser output
//   stable_o   debounced level
//   toggle_o   high in the clock whose edge flips stable_o
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic raw_o,
  output logic stable_o,
  output logic toggle_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          meta_q;
  logic          sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          mismatch;

  assign mismatch = (sync_q != stable_q);
  // The DEB_CYCLES-th consecutive mismatch is the one seen with the counter
  // already at DEB_CYCLES-1.
  assign toggle_o = mismatch && (cnt_q == CW'(DEB_CYCLES - 1));
  assign raw_o    = sync_q;
  assign stable_o = stable_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      if (toggle_o) begin
        stable_q <= sync_q;
        cnt_q    <= '0;
      end else if (mismatch) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/periph_buttons.sv
// periph_buttons
//   io-bus slave exposing debounced push-buttons: level state, sticky
//   rising-edge flags (write-1-to-clear), an interrupt mask and the raw
//   synchronised pins. Build option PERIPH_BUTTONS_FALL_EN adds a sticky
//   falling-edge register at 0x10 (needs ADDR_W >= 5).
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   addr              local byte address (bits [1:0] ignored)
//   data_in/data_out  write / read data
//   read, write       level requests held until ready
//   ready             one-clock completion pulse
//   buttons           raw asynchronous pins
//   irq               registered OR of pending, enabled flags
module periph_buttons
  import periph_buttons_pkg::*;
#(
  parameter int BTN_W       = 8,
  parameter int DEB_CYCLES  = 4,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  input  logic              read,
  input  logic              write,
  output logic              ready,
  input  logic [BTN_W-1:0]  buttons,
  output logic              irq
);

  logic [BTN_W-1:0] raw;
  logic [BTN_W-1:0] stable;
  logic [BTN_W-1:0] toggle;
  logic [BTN_W-1:0] rise;

  for (genvar gi = 0; gi < BTN_W; gi++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .pin_i    (buttons[gi]),
      .raw_o    (raw[gi]),
      .stable_o (stable[gi]),
      .toggle_o (toggle[gi])
    );
  end

  // A toggle while the level is still 0 is a 0->1 transition at this edge.
  assign rise = toggle & ~stable;

  bus_state_e        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [BTN_W-1:0]  wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [BTN_W-1:0]  edge_q, edge_d;
  logic [BTN_W-1:0]  irqen_q, irqen_d;
  logic [BTN_W-1:0]  w1c_edge;
  logic [BTN_W-1:0]  pending;
  logic              irq_q;
  logic              commit;
  logic [31:0]       offset;
  logic [31:0]       rdata;
  logic              unused_bus;

  // Only the low BTN_W data bits and the word part of the address matter.
  assign unused_bus = ^{data_in, addr[1:0]};
  assign offset     = 32'({addr_q, 2'b00});

`ifdef PERIPH_BUTTONS_FALL_EN
  logic [BTN_W-1:0] fall_q, fall_d;
  logic [BTN_W-1:0] w1c_fall;
  assign pending = (edge_q | fall_q) & irqen_q;
`else
  assign pending = edge_q & irqen_q;
`endif

  // Read mux samples the live registers, so data reflects the ACK clock.
  always_comb begin
    rdata = '0;
    case (offset)
      BTN_REG_STATE: rdata = 32'(stable);
      BTN_REG_EDGE:  rdata = 32'(edge_q);
      BTN_REG_IRQEN: rdata = 32'(irqen_q);
      BTN_REG_RAW:   rdata = 32'(raw);
`ifdef PERIPH_BUTTONS_FALL_EN
      BTN_REG_FALL:  rdata = 32'(fall_q);
`endif
      default:       rdata = '0;
    endcase
  end

  // Bus handshake: next state and outputs.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    ready    = 1'b0;
    data_out = '0;
    commit   = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (read || write) begin
          addr_d  = addr[ADDR_W-1:2];
          wdata_d = data_in[BTN_W-1:0];
          // read+write together is served as a write
          wr_d    = write;
          if (WAIT_STATES > 0) begin
            state_d = BUS_WAIT;
            wcnt_d  = 4'(WAIT_STATES - 1);
          end else begin
            state_d = BUS_ACK;
          end
        end
      end
      BUS_WAIT: begin
        if (wcnt_q == 4'd0) state_d = BUS_ACK;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      BUS_ACK: begin
        ready   = 1'b1;
        commit  = wr_q;
        if (!wr_q) data_out = rdata;
        state_d = BUS_DONE;
      end
      BUS_DONE: begin
        // Wait for the master to drop the request so it is served once.
        if (!read && !write) state_d = BUS_IDLE;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  // Register writes; a new edge beats a same-clock clear.
  always_comb begin
    w1c_edge = '0;
    irqen_d  = irqen_q;
`ifdef PERIPH_BUTTONS_FALL_EN
    w1c_fall = '0;
`endif
    if (commit) begin
      case (offset)
        BTN_REG_EDGE:  w1c_edge = wdata_q;
        BTN_REG_IRQEN: irqen_d  = wdata_q;
`ifdef PERIPH_BUTTONS_FALL_EN
        BTN_REG_FALL:  w1c_fall = wdata_q;
`endif
        default: ;
      endcase
    end
    edge_d = (edge_q & ~w1c_edge) | rise;
`ifdef PERIPH_BUTTONS_FALL_EN
    fall_d = (fall_q & ~w1c_fall) | (toggle & stable);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUS_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      edge_q  <= '0;
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      edge_q  <= edge_d;
      irqen_q <= irqen_d;
      irq_q   <= |pending;
    end
  end

`ifdef PERIPH_BUTTONS_FALL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fall_q <= '0;
    else     fall_q <= fall_d;
  end
`endif

  assign irq = irq_q;

endmodule
